// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter controller.
// Holds the default PC geometry, the next-PC select encoding and the
// priority function that maps the control inputs onto that encoding.
package pc_ctrl_pkg;

  localparam int unsigned PC_WIDTH      = 14;
  localparam int unsigned PC_RESET_ADDR = 0;
  localparam int unsigned PC_INC        = 1;
  localparam int unsigned PC_RAS_DEPTH  = 4;

  // Source of the next fetch PC
  typedef enum logic [2:0] {
    SEL_SEQ      = 3'd0,
    SEL_HOLD     = 3'd1,
    SEL_REDIRECT = 3'd2,
    SEL_CALL     = 3'd3,
    SEL_RET      = 3'd4
  } pc_sel_e;

  // Fixed priority: redirect > stall > ret > call > sequential
  function automatic pc_sel_e pc_select(
    input logic redirect,
    input logic stall,
    input logic ret,
    input logic call
  );
    if (redirect)   return SEL_REDIRECT;
    else if (stall) return SEL_HOLD;
    else if (ret)   return SEL_RET;
    else if (call)  return SEL_CALL;
    else            return SEL_SEQ;
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Control/status bundle of the program-counter controller.
// master: drives stall/redirect/call/ret requests, observes PC and stack status.
// slave : the controller itself.
interface pc_ctrl_if
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH
) ();

  logic             i_stall;
  logic             i_redirect;
  logic [WIDTH-1:0] i_redirect_target;
  logic             i_call;
  logic [WIDTH-1:0] i_call_target;
  logic             i_ret;
  logic [WIDTH-1:0] o_pc;
  logic             o_ras_empty;
  logic             o_ras_full;
  logic             o_ras_err;

  modport master (
    output i_stall, i_redirect, i_redirect_target,
    output i_call, i_call_target, i_ret,
    input  o_pc, o_ras_empty, o_ras_full, o_ras_err
  );

  modport slave (
    input  i_stall, i_redirect, i_redirect_target,
    input  i_call, i_call_target, i_ret,
    output o_pc, o_ras_empty, o_ras_full, o_ras_err
  );

endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer of DEPTH entries.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_push, i_push_data push a return address (overwrites oldest when full)
//   i_pop               pop the top entry (no-op on the pointer when empty)
//   o_top_c             combinational view of the current top entry
//   o_empty, o_full     registered count==0 / count==DEPTH flags
//   o_err               registered sticky overflow/underflow flag
// i_push and i_pop are expected to be mutually exclusive; push wins if not.
module pc_ras
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH,
  parameter int unsigned DEPTH = PC_RAS_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_top_c,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;   // next free slot; top is ptr_q-1
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             err_q, err_d;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two
  assign o_top_c = mem[ptr_q - PTR_W'(1)];

  // Next pointer/count/flags
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (i_push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (full_q) err_d = 1'b1;       // oldest entry overwritten, count saturates
      else        cnt_d = cnt_q + CNT_W'(1);
    end else if (i_pop) begin
      if (empty_q) begin
        err_d = 1'b1;
      end else begin
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    empty_d = (cnt_d == CNT_W'(0));
    full_d  = (cnt_d == CNT_W'(DEPTH));
  end

  // Stack bookkeeping registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  // Entry storage; contents survive reset, only the write is abandoned
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_push) mem[ptr_q] <= i_push_data;
  end

  assign o_empty = empty_q;
  assign o_full  = full_q;
  assign o_err   = err_q;

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller with return-address stack.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   bus (slave)   i_stall, i_redirect(+target), i_call(+target), i_ret in;
//                 o_pc, o_ras_empty, o_ras_full, o_ras_err out (all registered)
// Next PC priority: redirect > stall > ret > call > sequential (pc + INC).
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = PC_WIDTH,
  parameter int unsigned RESET_ADDR = PC_RESET_ADDR,
  parameter int unsigned INC        = PC_INC,
  parameter int unsigned RAS_DEPTH  = PC_RAS_DEPTH
) (
  input  logic     i_clk,
  input  logic     i_rst,
  pc_ctrl_if.slave bus
);

  pc_sel_e          sel_c;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] next_pc_c;
  logic [WIDTH-1:0] seq_pc_c;
  logic [WIDTH-1:0] ras_top_c;
  logic             push_c;
  logic             pop_c;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;

  // Sequential address, wraps modulo 2^WIDTH
  assign seq_pc_c = pc_q + WIDTH'(INC);

  // Select the next-PC source; stall and redirect suppress stack activity
  always_comb begin
    sel_c  = pc_select(bus.i_redirect, bus.i_stall, bus.i_ret, bus.i_call);
    push_c = (sel_c == SEL_CALL);
    pop_c  = (sel_c == SEL_RET);
  end

  // Next-PC datapath
  always_comb begin
    next_pc_c = seq_pc_c;
    unique case (sel_c)
      SEL_REDIRECT: next_pc_c = bus.i_redirect_target;
      SEL_HOLD:     next_pc_c = pc_q;
      SEL_CALL:     next_pc_c = bus.i_call_target;
      SEL_RET:      next_pc_c = ras_empty ? seq_pc_c : ras_top_c;  // underflow falls through
      default:      next_pc_c = seq_pc_c;
    endcase
  end

  // PC register
  always_ff @(posedge i_clk) begin
    if (i_rst) pc_q <= WIDTH'(RESET_ADDR);
    else       pc_q <= next_pc_c;
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push_c),
    .i_push_data (seq_pc_c),
    .i_pop       (pop_c),
    .o_top_c     (ras_top_c),
    .o_empty     (ras_empty),
    .o_full      (ras_full),
    .o_err       (ras_err)
  );

  assign bus.o_pc        = pc_q;
  assign bus.o_ras_empty = ras_empty;
  assign bus.o_ras_full  = ras_full;
  assign bus.o_ras_err   = ras_err;

endmodule
